spike_scheduler: RTL and testbench

SPIKE_SCHEDULER -- requirements
Module: spike_scheduler

---
 rtl/spike_scheduler_pkg.sv | 13 +
 rtl/spike_scheduler_prio_enc.sv | 23 ++
 rtl/spike_scheduler.sv | 120 ++++++++++++
 tb/tb_spike_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spike_scheduler_pkg.sv
// Shared neuron definitions: default requester geometry and scheduler FSM encoding.
package spike_scheduler_pkg;

   localparam int NUM_REQ_DEF = 16;
   localparam int IDX_W_DEF   = 4;
   localparam int CNT_W_DEF   = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } sched_state_e;

endpackage

// File: rtl/spike_scheduler_prio_enc.sv
// Parameterized priority encoder: reports the index of the highest set input bit.
module spike_scheduler_prio_enc #(
   parameter int IN_DSIZE  = 16,
   parameter int OUT_DSIZE = 4
) (
   input  logic [IN_DSIZE-1:0]  data_i,
   output logic [OUT_DSIZE-1:0] idx_o,
   output logic                 valid_o
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < IN_DSIZE; i++) begin
         if (data_i[i]) begin
            idx_o   = OUT_DSIZE'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spike_scheduler.sv
// Round-robin spike scheduler: collects per-neuron spikes, grants one per packet,
// and counts cycles in which a still-pending spike was overwritten.
module spike_scheduler
   import spike_scheduler_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDX_W   = IDX_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] spike_i,
   input  logic               enable_i,
   input  logic               flush_i,
   input  logic               pkt_ready_i,
   output logic               pkt_valid_o,
   output logic [IDX_W-1:0]   pkt_idx_o,
   output logic               busy_o,
   output logic [CNT_W-1:0]   drop_cnt_o
);

   sched_state_e       state_q, state_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [IDX_W-1:0]   last_idx_q, last_idx_d;
   logic [IDX_W-1:0]   pkt_idx_q, pkt_idx_d;
   logic               pkt_valid_q, pkt_valid_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic [NUM_REQ-1:0] lower_mask, masked, clr_mask;
   logic [IDX_W-1:0]   m_idx, u_idx, winner;
   logic               m_valid, u_valid;
   logic               grant, drop;

   // Round-robin pointer: only requesters strictly below the last winner are preferred.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         lower_mask[i] = (IDX_W'(i) < last_idx_q);
      end
      masked = pending_q & lower_mask;
   end

   spike_scheduler_prio_enc #(.IN_DSIZE(NUM_REQ), .OUT_DSIZE(IDX_W)) u_enc_masked (
      .data_i  (masked),
      .idx_o   (m_idx),
      .valid_o (m_valid)
   );

   spike_scheduler_prio_enc #(.IN_DSIZE(NUM_REQ), .OUT_DSIZE(IDX_W)) u_enc_unmasked (
      .data_i  (pending_q),
      .idx_o   (u_idx),
      .valid_o (u_valid)
   );

   assign winner = m_valid ? m_idx : u_idx;

   always_comb begin
      state_d     = state_q;
      pkt_valid_d = pkt_valid_q;
      pkt_idx_d   = pkt_idx_q;
      grant       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_i && u_valid) begin
               grant       = 1'b1;
               pkt_idx_d   = winner;
               pkt_valid_d = 1'b1;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (pkt_valid_q && pkt_ready_i) begin
               if (enable_i && u_valid) begin
                  grant     = 1'b1;
                  pkt_idx_d = winner;
               end else begin
                  pkt_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      for (int i = 0; i < NUM_REQ; i++) begin
         clr_mask[i] = grant && (winner == IDX_W'(i));
      end

      // A spike on the bit granted this cycle simply re-arms it; only a surviving bit counts as a drop.
      drop       = !flush_i && |(spike_i & pending_q & ~clr_mask);
      pending_d  = flush_i ? '0 : ((pending_q & ~clr_mask) | spike_i);
      last_idx_d = grant ? winner : last_idx_q;
      drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         last_idx_q  <= IDX_W'(NUM_REQ - 1);
         pkt_idx_q   <= '0;
         pkt_valid_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         last_idx_q  <= last_idx_d;
         pkt_idx_q   <= pkt_idx_d;
         pkt_valid_q <= pkt_valid_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign pkt_valid_o = pkt_valid_q;
   assign pkt_idx_o   = pkt_idx_q;
   assign busy_o      = pkt_valid_q || (|pending_q);
   assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed bench for spike_scheduler: grant order, back-pressure, drops, flush and reset.
module tb_spike_scheduler;

   logic        clk;
   logic        rst_n;
   logic [15:0] spike_i;
   logic        enable_i;
   logic        flush_i;
   logic        pkt_ready_i;
   logic        pkt_valid_o;
   logic [3:0]  pkt_idx_o;
   logic        busy_o;
   logic [7:0]  drop_cnt_o;

   int total = 0;
   int bad   = 0;

   spike_scheduler #(.NUM_REQ(16), .IDX_W(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spike_i     (spike_i),
      .enable_i    (enable_i),
      .flush_i     (flush_i),
      .pkt_ready_i (pkt_ready_i),
      .pkt_valid_o (pkt_valid_o),
      .pkt_idx_o   (pkt_idx_o),
      .busy_o      (busy_o),
      .drop_cnt_o  (drop_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic check_pkt(input string tag, input logic v, input logic [3:0] idx);
      check({tag, "_valid"}, 32'(pkt_valid_o), 32'(v));
      if (v) check({tag, "_idx"}, 32'(pkt_idx_o), 32'(idx));
   endtask

   initial begin
      rst_n       = 1'b0;
      spike_i     = '0;
      enable_i    = 1'b1;
      flush_i     = 1'b0;
      pkt_ready_i = 1'b1;
      tick();
      tick();
      check("rst_valid", 32'(pkt_valid_o), 32'd0);
      check("rst_idx",   32'(pkt_idx_o),   32'd0);
      check("rst_busy",  32'(busy_o),      32'd0);
      check("rst_drop",  32'(drop_cnt_o),  32'd0);
      rst_n = 1'b1;

      // Single spike: one-cycle latency, one packet, then idle.
      spike_i = 16'h0001;
      tick();
      spike_i = '0;
      check("single_lat_valid", 32'(pkt_valid_o), 32'd0);
      check("single_lat_busy",  32'(busy_o),      32'd1);
      tick();
      check_pkt("single_pkt", 1'b1, 4'd0);
      tick();
      check_pkt("single_done", 1'b0, 4'd0);
      check("single_busy", 32'(busy_o), 32'd0);

      // Round-robin descending order starting below NUM_REQ-1.
      do_reset();
      spike_i = 16'h8421;
      tick();
      spike_i = '0;
      tick();
      check_pkt("rr_0", 1'b1, 4'd10);
      tick();
      check_pkt("rr_1", 1'b1, 4'd5);
      tick();
      check_pkt("rr_2", 1'b1, 4'd0);
      tick();
      check_pkt("rr_3", 1'b1, 4'd15);
      tick();
      check_pkt("rr_end", 1'b0, 4'd0);
      check("rr_busy", 32'(busy_o), 32'd0);

      // Back-pressure: idx 2 held five cycles (enable dropped meanwhile), then 2 and 1 accepted.
      spike_i     = 16'h0006;
      pkt_ready_i = 1'b0;
      tick();
      spike_i = '0;
      tick();
      check_pkt("bp_hold0", 1'b1, 4'd2);
      enable_i = 1'b0;
      for (int i = 1; i < 5; i++) begin
         tick();
         check_pkt($sformatf("bp_hold%0d", i), 1'b1, 4'd2);
      end
      enable_i    = 1'b1;
      pkt_ready_i = 1'b1;
      tick();
      check_pkt("bp_next", 1'b1, 4'd1);
      tick();
      check_pkt("bp_end", 1'b0, 4'd0);

      // Drops with grants blocked, then saturation.
      do_reset();
      enable_i    = 1'b0;
      pkt_ready_i = 1'b0;
      spike_i     = 16'h0010;
      tick();
      tick();
      tick();
      check("drop_two", 32'(drop_cnt_o), 32'd2);
      check("drop_no_pkt", 32'(pkt_valid_o), 32'd0);
      for (int i = 0; i < 252; i++) tick();
      check("drop_254", 32'(drop_cnt_o), 32'd254);
      tick();
      check("drop_255", 32'(drop_cnt_o), 32'd255);
      for (int i = 0; i < 45; i++) tick();
      check("drop_sat", 32'(drop_cnt_o), 32'd255);
      spike_i  = '0;
      enable_i = 1'b1;

      // Spike on the bit being granted is not a drop and re-arms the bit.
      do_reset();
      spike_i = 16'h0010;
      tick();
      tick();
      spike_i = '0;
      check_pkt("regrant_first", 1'b1, 4'd4);
      check("regrant_nodrop", 32'(drop_cnt_o), 32'd0);
      pkt_ready_i = 1'b1;
      tick();
      check_pkt("regrant_again", 1'b1, 4'd4);
      tick();
      check_pkt("regrant_end", 1'b0, 4'd0);

      // Flush in the cycle after the first grant: in-flight idx 6 survives, rest discarded.
      do_reset();
      spike_i = 16'h00F0;
      tick();
      spike_i = '0;
      tick();
      check_pkt("flush_first", 1'b1, 4'd7);
      flush_i = 1'b1;
      spike_i = 16'h0001;
      tick();
      flush_i     = 1'b0;
      spike_i     = '0;
      pkt_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_pkt($sformatf("flush_hold%0d", i), 1'b1, 4'd6);
         tick();
      end
      pkt_ready_i = 1'b1;
      tick();
      check_pkt("flush_end", 1'b0, 4'd0);
      check("flush_busy", 32'(busy_o), 32'd0);
      check("flush_nodrop", 32'(drop_cnt_o), 32'd0);

      // Reset during SEND with pending 0x0300 discards everything immediately.
      do_reset();
      pkt_ready_i = 1'b0;
      spike_i     = 16'h0700;
      tick();
      spike_i = '0;
      tick();
      check_pkt("mid_send", 1'b1, 4'd10);
      check("mid_busy", 32'(busy_o), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(pkt_valid_o), 32'd0);
      check("mid_rst_busy",  32'(busy_o),      32'd0);
      check("mid_rst_idx",   32'(pkt_idx_o),   32'd0);
      tick();
      rst_n       = 1'b1;
      pkt_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("post_rst_valid%0d", i), 32'(pkt_valid_o), 32'd0);
      end
      check("post_rst_busy", 32'(busy_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
